posi_satd_cost_accumulate: RTL and testbench

Column-stage SATD back end of the post-intra cost calculator. It consumes the column-ordered beats produced by the satd transpose buffer, applies the second (vertical) Hadamard pass, sums absolute coefficients, normalises per 4x4 or 8x8 block, and accumulates one SATD cost per CU. It sits between the transpose buffer and the post-intra mode-decision logic.

---
 rtl/posi_satd_cost_accumulate_pkg.sv | 21 ++
 rtl/posi_satd_cost_hadamard_col.sv | 48 ++++
 rtl/posi_satd_cost_accumulate.sv | 171 +++++++++++++++++
 tb/tb_posi_satd_cost_accumulate.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/posi_satd_cost_accumulate_pkg.sv
// Shared constants and beat tag type for the column-stage SATD cost accumulator.
// Block-size codes mirror the SIZE_* values of enc_defines.v.
package posi_satd_cost_accumulate_pkg;

    localparam logic [1:0] SIZE_04 = 2'd0;
    localparam logic [1:0] SIZE_08 = 2'd1;
    localparam logic [1:0] SIZE_16 = 2'd2;
    localparam logic [1:0] SIZE_32 = 2'd3;

    // Growth of an 8-point Hadamard output over its input width.
    localparam int unsigned HAD_GROWTH = 3;
    localparam int unsigned LANES      = 16;

    typedef struct packed {
        logic val;
        logic blk_end;
        logic last;
        logic is4;
    } beat_tag_t;

endpackage

// File: rtl/posi_satd_cost_hadamard_col.sv
// Combinational 8-lane Hadamard butterfly: one 8-point transform, or two
// independent 4-point transforms on lanes 3..0 and 7..4 when mode4_i is set.
module posi_satd_cost_hadamard_col
    import posi_satd_cost_accumulate_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 12
) (
    input  logic                                  mode4_i,
    input  logic [8*DATA_WIDTH-1:0]               col_i,
    output logic [8*(DATA_WIDTH+HAD_GROWTH)-1:0]  had_o
);

    localparam int unsigned HW = DATA_WIDTH + HAD_GROWTH;

    logic signed [HW-1:0] x [8];
    logic signed [HW-1:0] a [8];
    logic signed [HW-1:0] b [8];
    logic signed [HW-1:0] c [8];

    for (genvar i = 0; i < 8; i++) begin : g_ext
        assign x[i] = {{HAD_GROWTH{col_i[i*DATA_WIDTH+DATA_WIDTH-1]}},
                       col_i[i*DATA_WIDTH +: DATA_WIDTH]};
    end

    for (genvar k = 0; k < 4; k++) begin : g_st1
        assign a[2*k]   = x[2*k] + x[2*k+1];
        assign a[2*k+1] = x[2*k] - x[2*k+1];
    end

    // Distance-2 butterflies stay inside each 4-lane half, completing the 4-point pair.
    for (genvar g = 0; g < 2; g++) begin : g_st2
        for (genvar h = 0; h < 2; h++) begin : g_pair
            localparam int J = 4*g + h;
            assign b[J]   = a[J] + a[J+2];
            assign b[J+2] = a[J] - a[J+2];
        end
    end

    for (genvar j = 0; j < 4; j++) begin : g_st3
        assign c[j]   = b[j] + b[j+4];
        assign c[j+4] = b[j] - b[j+4];
    end

    for (genvar i = 0; i < 8; i++) begin : g_out
        assign had_o[i*HW +: HW] = mode4_i ? b[i] : c[i];
    end

endmodule

// File: rtl/posi_satd_cost_accumulate.sv
// Column-stage SATD back end: vertical Hadamard, abs-sum, per-block normalisation
// and per-CU cost accumulation over a four-stage pipeline.
module posi_satd_cost_accumulate
    import posi_satd_cost_accumulate_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 12,
    parameter int unsigned COST_WIDTH = 24
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [1:0]               size_i,
    input  logic                     val_i,
    input  logic                     last_i,
    input  logic [DATA_WIDTH*16-1:0] dat_i,
    output logic                     cost_val_o,
    output logic [COST_WIDTH-1:0]    cost_o
);

    localparam int unsigned HW = DATA_WIDTH + HAD_GROWTH;
    localparam int unsigned SW = DATA_WIDTH + 7;
    localparam int unsigned BW = DATA_WIDTH + 9;
    localparam int unsigned AW = ((COST_WIDTH > BW) ? COST_WIDTH : BW) + 1;
    localparam logic [COST_WIDTH-1:0] COST_MAX = {COST_WIDTH{1'b1}};

    // ---------------- input side: beat counter and tags ----------------
    logic      is4;
    logic [1:0] cnt_r;
    beat_tag_t tag0;

    assign is4 = (size_i == SIZE_04);

    always_comb begin
        tag0         = '0;
        tag0.val     = val_i;
        tag0.blk_end = val_i & (is4 | last_i | (cnt_r == 2'd3));
        tag0.last    = val_i & last_i;
        tag0.is4     = val_i & is4;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_r <= 2'd0;
        end else if (val_i) begin
            if (last_i)    cnt_r <= 2'd0;
            else if (!is4) cnt_r <= cnt_r + 2'd1;
        end
    end

    // ---------------- S1: vertical Hadamard ----------------
    logic [8*HW-1:0]     had_hi;
    logic [8*HW-1:0]     had_lo;
    logic [LANES*HW-1:0] had_r;
    beat_tag_t           tag1;

    posi_satd_cost_hadamard_col #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_had_hi (
        .mode4_i (is4),
        .col_i   (dat_i[DATA_WIDTH*16-1:DATA_WIDTH*8]),
        .had_o   (had_hi)
    );

    posi_satd_cost_hadamard_col #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_had_lo (
        .mode4_i (is4),
        .col_i   (dat_i[DATA_WIDTH*8-1:0]),
        .had_o   (had_lo)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            had_r <= '0;
            tag1  <= '0;
        end else begin
            tag1 <= tag0;
            if (val_i) had_r <= {had_hi, had_lo};
        end
    end

    // ---------------- S2: absolute-value adder tree ----------------
    logic [HW-1:0] coef;
    logic [HW-1:0] mag;
    logic [SW-1:0] beat_sum;
    logic [SW-1:0] sum_r;
    beat_tag_t     tag2;

    always_comb begin
        coef     = '0;
        mag      = '0;
        beat_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            coef     = had_r[i*HW +: HW];
            mag      = coef[HW-1] ? (~coef + HW'(1)) : coef;
            beat_sum = beat_sum + SW'(mag);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sum_r <= '0;
            tag2  <= '0;
        end else begin
            tag2 <= tag1;
            if (tag1.val) sum_r <= beat_sum;
        end
    end

    // ---------------- S3: block accumulate and normalise ----------------
    logic [BW-1:0] blk_acc_r;
    logic [BW-1:0] blk_total;
    logic [BW-1:0] blk_norm;
    logic [BW-1:0] blk_cost_r;
    logic          blk_val_r;
    logic          blk_last_r;

    always_comb begin
        blk_total = blk_acc_r + BW'(sum_r);
        blk_norm  = tag2.is4 ? ((blk_total + BW'(1)) >> 1) : ((blk_total + BW'(2)) >> 2);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            blk_acc_r  <= '0;
            blk_cost_r <= '0;
            blk_val_r  <= 1'b0;
            blk_last_r <= 1'b0;
        end else begin
            blk_val_r  <= tag2.val & tag2.blk_end;
            blk_last_r <= tag2.val & tag2.blk_end & tag2.last;
            if (tag2.val) begin
                if (tag2.blk_end) begin
                    blk_cost_r <= blk_norm;
                    blk_acc_r  <= '0;
                end else begin
                    blk_acc_r  <= blk_total;
                end
            end
        end
    end

    // ---------------- S4: CU accumulate with saturation ----------------
    logic [COST_WIDTH-1:0] acc_r;
    logic [AW-1:0]         acc_sum;
    logic [COST_WIDTH-1:0] acc_sat;

    // The running sum saturates too, so a huge CU can never wrap back below the clamp.
    always_comb begin
        acc_sum = AW'(acc_r) + AW'(blk_cost_r);
        acc_sat = (acc_sum > AW'(COST_MAX)) ? COST_MAX : acc_sum[COST_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc_r      <= '0;
            cost_o     <= '0;
            cost_val_o <= 1'b0;
        end else begin
            cost_val_o <= blk_val_r & blk_last_r;
            if (blk_val_r) begin
                if (blk_last_r) begin
                    cost_o <= acc_sat;
                    acc_r  <= '0;
                end else begin
                    acc_r  <= acc_sat;
                end
            end
        end
    end

endmodule

// File: tb/tb_posi_satd_cost_accumulate.sv
// Directed scoreboard bench: expected CU costs and pulse cycles are queued when
// a last beat is driven and checked when cost_val_o pulses.
module tb_posi_satd_cost_accumulate;

    localparam int DW = 12;

    logic           clk = 1'b0;
    logic           rstn;
    logic [1:0]     size_i;
    logic           val_i;
    logic           last_i;
    logic [DW*16-1:0] dat_i;
    logic           cost_val_o;
    logic [23:0]    cost_o;
    logic           sat_val_o;
    logic [11:0]    sat_cost_o;

    typedef struct {
        logic [23:0] cost;
        int          cyc;
    } exp_t;

    exp_t        q24[$];
    exp_t        q12[$];
    int          cyc = 0;
    int          nvec = 0;
    int          nerr = 0;
    logic [23:0] held24 = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    posi_satd_cost_accumulate #(
        .DATA_WIDTH (DW),
        .COST_WIDTH (24)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .size_i     (size_i),
        .val_i      (val_i),
        .last_i     (last_i),
        .dat_i      (dat_i),
        .cost_val_o (cost_val_o),
        .cost_o     (cost_o)
    );

    posi_satd_cost_accumulate #(
        .DATA_WIDTH (DW),
        .COST_WIDTH (12)
    ) dut_sat (
        .clk        (clk),
        .rstn       (rstn),
        .size_i     (size_i),
        .val_i      (val_i),
        .last_i     (last_i),
        .dat_i      (dat_i),
        .cost_val_o (sat_val_o),
        .cost_o     (sat_cost_o)
    );

    function automatic logic [DW*16-1:0] fill(input logic [DW-1:0] v);
        return {16{v}};
    endfunction

    function automatic logic [DW*16-1:0] lane15(input logic [DW-1:0] v);
        logic [DW*16-1:0] d;
        d = '0;
        d[DW*16-1 -: DW] = v;
        return d;
    endfunction

    // Drive one beat right after a rising edge; a last beat queues its expected cost.
    task automatic send(input logic [1:0] sz, input logic lst, input logic [DW*16-1:0] d,
                        input logic [23:0] exp_cost, input int gap);
        exp_t e;
        size_i = sz;
        last_i = lst;
        dat_i  = d;
        val_i  = 1'b1;
        if (lst) begin
            e.cost = exp_cost;
            e.cyc  = cyc + 4;
            q24.push_back(e);
            e.cost = (exp_cost > 24'd4095) ? 24'd4095 : exp_cost;
            q12.push_back(e);
        end
        @(posedge clk); #1;
        val_i  = 1'b0;
        last_i = 1'b0;
        dat_i  = '0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q24.size() != 0 || q12.size() != 0) && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        nvec++;
        assert (q24.size() == 0 && q12.size() == 0) else begin
            nerr++;
            $error("FAIL drain: pending %0d/%0d expected 0", q24.size(), q12.size());
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rstn) held24 = '0;
        if (cost_val_o) begin
            nvec++;
            assert (q24.size() > 0) else begin
                nerr++;
                $error("FAIL spurious24: pulse at cyc %0d, cost %0d, none expected", cyc, cost_o);
            end
            if (q24.size() > 0) begin
                e = q24.pop_front();
                nvec++;
                assert (cost_o === e.cost) else begin
                    nerr++;
                    $error("FAIL cost24: got %0d expected %0d", cost_o, e.cost);
                end
                nvec++;
                assert (cyc === e.cyc) else begin
                    nerr++;
                    $error("FAIL latency24: pulse cyc %0d expected %0d", cyc, e.cyc);
                end
            end
            held24 = cost_o;
        end else if (rstn) begin
            assert (cost_o === held24) else begin
                nerr++;
                $error("FAIL hold24: got %0d expected %0d", cost_o, held24);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (sat_val_o) begin
            nvec++;
            assert (q12.size() > 0) else begin
                nerr++;
                $error("FAIL spurious12: pulse at cyc %0d, cost %0d, none expected", cyc, sat_cost_o);
            end
            if (q12.size() > 0) begin
                e = q12.pop_front();
                nvec++;
                assert ({12'd0, sat_cost_o} === e.cost) else begin
                    nerr++;
                    $error("FAIL cost12: got %0d expected %0d", sat_cost_o, e.cost);
                end
                nvec++;
                assert (cyc === e.cyc) else begin
                    nerr++;
                    $error("FAIL latency12: pulse cyc %0d expected %0d", cyc, e.cyc);
                end
            end
        end
    end

    task automatic check_reset(input string tag);
        @(negedge clk);
        nvec++;
        assert (cost_o === 24'd0 && cost_val_o === 1'b0 && sat_cost_o === 12'd0
                && sat_val_o === 1'b0) else begin
            nerr++;
            $error("FAIL %s: cost %0d val %0b sat %0d/%0b expected 0/0", tag, cost_o,
                   cost_val_o, sat_cost_o, sat_val_o);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rstn   = 1'b0;
        size_i = 2'd0;
        val_i  = 1'b0;
        last_i = 1'b0;
        dat_i  = '0;
        repeat (2) @(posedge clk);
        check_reset("reset_state");
        rstn = 1'b1;
        @(posedge clk); #1;

        // 4x4 single-beat CUs
        send(2'd0, 1'b1, fill(12'd1), 24'd8, 3);
        send(2'd0, 1'b1, fill(12'hFFF), 24'd8, 3);
        send(2'd0, 1'b1, lane15(12'd3), 24'd6, 3);
        drain();

        // 8x8 block, back-to-back then with 2-cycle gaps
        for (int i = 0; i < 4; i++) send(2'd1, i == 3, fill(12'd1), 24'd16, 0);
        for (int i = 0; i < 4; i++) send(2'd1, i == 3, fill(12'd1), 24'd16, 2);
        drain();

        // 16x16 with random gaps, immediately followed by a 4x4 CU
        for (int i = 0; i < 16; i++)
            send(2'd2, i == 15, fill(12'd1), 24'd64, (i == 15) ? 0 : $urandom_range(0, 2));
        send(2'd0, 1'b1, fill(12'd1), 24'd8, 0);

        // Back-to-back single-beat CUs with distinct costs
        send(2'd0, 1'b1, lane15(12'd3), 24'd6, 0);
        send(2'd0, 1'b1, fill(12'hFFF), 24'd8, 0);
        // Multi-block 4x4 CU, then partial 8x8 blocks ended by last
        for (int i = 0; i < 4; i++) send(2'd0, i == 3, fill(12'd1), 24'd32, 0);
        send(2'd1, 1'b0, fill(12'd1), 24'd0, 0);
        send(2'd1, 1'b1, fill(12'd1), 24'd8, 0);
        send(2'd1, 1'b1, lane15(12'd3), 24'd6, 0);
        drain();

        // Reset mid-CU discards the partial sums
        send(2'd1, 1'b0, fill(12'd1), 24'd0, 0);
        send(2'd1, 1'b0, fill(12'd1), 24'd0, 1);
        rstn = 1'b0;
        check_reset("reset_mid_cu");
        rstn = 1'b1;
        @(posedge clk); #1;
        send(2'd0, 1'b1, fill(12'd1), 24'd8, 0);
        drain();

        // 32x32 at max positive: 16 blocks of 32752, clamps at 4095 in the 12-bit instance
        for (int i = 0; i < 64; i++) send(2'd3, i == 63, fill(12'h7FF), 24'd524032, 0);
        drain();

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
